// File: rtl/rle_encoder_stream.sv
// Streaming run-length encoder: one pixel per beat in, (value, run-length) entries out.
// A single output register holds each entry; frame end is marked by in_last_i.
module rle_encoder_stream #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned CNT_W  = 8,
    parameter int unsigned STAT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              raw_mode_i,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic              in_valid_i,
    input  logic              in_last_i,
    output logic              in_ready_o,
    output logic [DATA_W-1:0] out_data_o,
    output logic [CNT_W-1:0]  out_count_o,
    output logic              out_last_o,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic              done_o,
    output logic              busy_o,
    output logic [STAT_W-1:0] original_count_o,
    output logic [STAT_W-1:0] compressed_count_o
);

    localparam logic [CNT_W-1:0]  CntMax  = '1;
    localparam logic [STAT_W-1:0] StatMax = '1;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StFlush
    } state_e;

    state_e              state_q, state_d;
    logic                raw_q, raw_d;
    logic                first_q, first_d;
    logic [DATA_W-1:0]   run_val_q, run_val_d;
    logic [CNT_W-1:0]    run_cnt_q, run_cnt_d;
    logic                out_valid_q, out_valid_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic [CNT_W-1:0]    out_count_q, out_count_d;
    logic                out_last_q, out_last_d;
    logic                done_q, done_d;
    logic [STAT_W-1:0]   orig_q, orig_d;
    logic [STAT_W-1:0]   comp_q, comp_d;

    logic out_free;
    logic in_ready;
    logic accept;
    logic xfer;

    // The output register is free if empty or draining this cycle.
    assign out_free = !out_valid_q || out_ready_i;
    assign in_ready = (state_q == StRun) && out_free;
    assign accept   = in_valid_i && in_ready;
    assign xfer     = out_valid_q && out_ready_i;

    always_comb begin
        state_d     = state_q;
        raw_d       = raw_q;
        first_d     = first_q;
        run_val_d   = run_val_q;
        run_cnt_d   = run_cnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_count_d = out_count_q;
        out_last_d  = out_last_q;
        orig_d      = orig_q;
        comp_d      = comp_q;
        done_d      = xfer && out_last_q;

        if (xfer) begin
            out_valid_d = 1'b0;
            comp_d      = (comp_q == StatMax) ? comp_q : comp_q + STAT_W'(1);
        end

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    orig_d  = '0;
                    comp_d  = '0;
                    first_d = 1'b1;
                    raw_d   = raw_mode_i;
                    state_d = StRun;
                end
            end
            StRun: begin
                if (accept) begin
                    orig_d = (orig_q == StatMax) ? orig_q : orig_q + STAT_W'(1);
                    if (first_q) begin
                        run_val_d = in_data_i;
                        run_cnt_d = CNT_W'(1);
                        first_d   = 1'b0;
                    end else if (!raw_q && (in_data_i == run_val_q) && (run_cnt_q != CntMax)) begin
                        run_cnt_d = run_cnt_q + CNT_W'(1);
                    end else begin
                        out_valid_d = 1'b1;
                        out_data_d  = run_val_q;
                        out_count_d = run_cnt_q;
                        out_last_d  = 1'b0;
                        run_val_d   = in_data_i;
                        run_cnt_d   = CNT_W'(1);
                    end
                    if (in_last_i) begin
                        state_d = StFlush;
                    end
                end
            end
            StFlush: begin
                if (out_free) begin
                    out_valid_d = 1'b1;
                    out_data_d  = run_val_q;
                    out_count_d = run_cnt_q;
                    out_last_d  = 1'b1;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            raw_q       <= 1'b0;
            first_q     <= 1'b1;
            run_val_q   <= '0;
            run_cnt_q   <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_count_q <= '0;
            out_last_q  <= 1'b0;
            done_q      <= 1'b0;
            orig_q      <= '0;
            comp_q      <= '0;
        end else begin
            state_q     <= state_d;
            raw_q       <= raw_d;
            first_q     <= first_d;
            run_val_q   <= run_val_d;
            run_cnt_q   <= run_cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_count_q <= out_count_d;
            out_last_q  <= out_last_d;
            done_q      <= done_d;
            orig_q      <= orig_d;
            comp_q      <= comp_d;
        end
    end

    assign in_ready_o         = in_ready;
    assign out_valid_o        = out_valid_q;
    assign out_data_o         = out_data_q;
    assign out_count_o        = out_count_q;
    assign out_last_o         = out_last_q;
    assign done_o             = done_q;
    assign busy_o             = (state_q != StIdle);
    assign original_count_o   = orig_q;
    assign compressed_count_o = comp_q;

endmodule
